// File: rtl/audio_i2s_tx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_i2s_tx_pkg                                                 |
// | Shared audio constants and the unsigned-to-signed sample helper. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package audio_i2s_tx_pkg;

    localparam int              c_SAMPLE_W      = 8;
    localparam logic [7:0]      c_MIDSCALE      = 8'h80;
    localparam int              c_DEF_SLOT_BITS = 16;

    typedef logic [c_SAMPLE_W-1:0] sample_t;

    // Offset-binary to two's complement: inverting the MSB subtracts midscale.
    function automatic sample_t to_signed_sample(input sample_t s);
        return {~s[c_SAMPLE_W-1], s[c_SAMPLE_W-2:0]};
    endfunction

endpackage : audio_i2s_tx_pkg
`default_nettype wire

// File: rtl/audio_bclk_divider.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_bclk_divider                                               |
// | Divides the system clock into BCLK and flags the falling edge.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module audio_bclk_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_bclk,
    output logic o_fall
);

    localparam int                 c_CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_bclk;
    logic               w_term;

    assign w_term = (r_cnt == c_CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_bclk <= 1'b0;
        end else if (w_term) begin
            r_cnt  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // High during the cycle whose closing edge drives BCLK 1->0, so the
    // consumer can update its outputs on that same edge.
    assign o_fall = w_term & r_bclk;
    assign o_bclk = r_bclk;

endmodule : audio_bclk_divider
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | audio_i2s_tx                                                     |
// | 8-bit mixer sample to I2S serialiser, same slot on L and R.      |
// | Optional: AUDIO_I2S_UNDERRUN_CNT_EN adds a saturating counter.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module audio_i2s_tx
    import audio_i2s_tx_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int SLOT_BITS = c_DEF_SLOT_BITS
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [c_SAMPLE_W-1:0] i_sample,
    input  logic                  i_sample_stb,
    output logic                  o_bclk,
    output logic                  o_lrclk,
    output logic                  o_sdata,
    output logic                  o_sample_req,
    output logic                  o_underrun,
    output logic                  o_overrun
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    ,
    output logic [7:0]            o_underrun_count
`endif
);

    localparam int               c_FRAME_BITS = 2 * SLOT_BITS;
    localparam int               c_K_W        = $clog2(c_FRAME_BITS);
    localparam int               c_PAD_W      = SLOT_BITS - c_SAMPLE_W;
    localparam logic [c_K_W-1:0] c_K_LAST     = c_K_W'(c_FRAME_BITS - 1);
    localparam logic [c_K_W-1:0] c_K_LR_ON    = c_K_W'(SLOT_BITS - 1);
    localparam logic [c_K_W-1:0] c_K_RIGHT    = c_K_W'(SLOT_BITS);

    logic                  w_fall;
    logic [c_K_W-1:0]      r_k;
    logic [c_K_W-1:0]      w_k_next;
    logic                  w_load;
    logic                  w_lrclk_next;
    logic                  w_underrun;
    sample_t               w_load_sample;
    logic [SLOT_BITS-1:0]  w_load_word;

    logic [SLOT_BITS-1:0]  r_word;
    logic [SLOT_BITS-2:0]  r_shift;
    sample_t               r_hold;
    logic                  r_fresh;
    logic                  r_lrclk;
    logic                  r_sdata;
    logic                  r_req;
    logic                  r_underrun;
    logic                  r_overrun;

    audio_bclk_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_bclk  (o_bclk),
        .o_fall  (w_fall)
    );

    assign w_k_next      = (r_k == c_K_LAST) ? '0 : r_k + 1'b1;
    assign w_load        = w_fall && (w_k_next == '0);
    // Word select switches one bit ahead of the slot it announces.
    assign w_lrclk_next  = (w_k_next >= c_K_LR_ON) && (w_k_next != c_K_LAST);
    // A strobe landing on the load edge goes straight into the frame.
    assign w_load_sample = i_sample_stb ? i_sample : r_hold;
    assign w_load_word   = {to_signed_sample(w_load_sample), {c_PAD_W{1'b0}}};
    assign w_underrun    = w_load & ~r_fresh & ~i_sample_stb;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_k        <= c_K_LAST;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
            r_word     <= '0;
            r_shift    <= '0;
            r_hold     <= c_MIDSCALE;
            r_fresh    <= 1'b0;
            r_req      <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_req      <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;

            if (w_fall) begin
                r_k     <= w_k_next;
                r_lrclk <= w_lrclk_next;
                if (w_load) begin
                    r_word     <= w_load_word;
                    r_sdata    <= w_load_word[SLOT_BITS-1];
                    r_shift    <= w_load_word[SLOT_BITS-2:0];
                    r_req      <= 1'b1;
                    r_underrun <= w_underrun;
                end else if (w_k_next == c_K_RIGHT) begin
                    r_sdata    <= r_word[SLOT_BITS-1];
                    r_shift    <= r_word[SLOT_BITS-2:0];
                end else begin
                    r_sdata    <= r_shift[SLOT_BITS-2];
                    r_shift    <= {r_shift[SLOT_BITS-3:0], 1'b0};
                end
            end

            if (i_sample_stb) begin
                r_hold    <= i_sample;
                r_fresh   <= ~w_load;
                r_overrun <= r_fresh & ~w_load;
            end else if (w_load) begin
                r_fresh   <= 1'b0;
            end
        end
    end

    assign o_lrclk      = r_lrclk;
    assign o_sdata      = r_sdata;
    assign o_sample_req = r_req;
    assign o_underrun   = r_underrun;
    assign o_overrun    = r_overrun;

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    logic [7:0] r_urun_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_urun_cnt <= '0;
        end else if (w_underrun && (r_urun_cnt != 8'hFF)) begin
            r_urun_cnt <= r_urun_cnt + 8'd1;
        end
    end

    assign o_underrun_count = r_urun_cnt;
`endif

endmodule : audio_i2s_tx
`default_nettype wire

// File: tb/tb_audio_i2s_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_audio_i2s_tx                                                  |
// | Directed self-checking bench, CLK_DIV=2, SLOT_BITS=16.           |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_audio_i2s_tx;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_sample;
    logic       i_sample_stb;
    logic       o_bclk;
    logic       o_lrclk;
    logic       o_sdata;
    logic       o_sample_req;
    logic       o_underrun;
    logic       o_overrun;
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
    logic [7:0] o_underrun_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] frame_data;
    logic [31:0] frame_lr;

    localparam logic [31:0] c_LR_PATTERN = 32'h0001_FFFE;

    always #5 i_clk = ~i_clk;

    audio_i2s_tx #(
        .CLK_DIV   (2),
        .SLOT_BITS (16)
    ) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_sample         (i_sample),
        .i_sample_stb     (i_sample_stb),
        .o_bclk           (o_bclk),
        .o_lrclk          (o_lrclk),
        .o_sdata          (o_sdata),
        .o_sample_req     (o_sample_req),
        .o_underrun       (o_underrun),
        .o_overrun        (o_overrun)
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
        ,
        .o_underrun_count (o_underrun_count)
`endif
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the edge on which BCLK falls (bounded).
    task automatic wait_fall();
        logic prev;
        bit   seen;
        prev = o_bclk;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            step();
            if (prev === 1'b1 && o_bclk === 1'b0) seen = 1'b1;
            prev = o_bclk;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait_fall: observed no BCLK fall in 16 clocks, expected one");
        end
    endtask

    // Called with k=0 visible; returns bits for k=0..31, MSB = k0.
    task automatic collect_frame(output logic [31:0] data, output logic [31:0] lr);
        data[31] = o_sdata;
        lr[31]   = o_lrclk;
        for (int i = 30; i >= 0; i--) begin
            wait_fall();
            data[i] = o_sdata;
            lr[i]   = o_lrclk;
        end
    endtask

    task automatic strobe(input logic [7:0] s);
        i_sample     = s;
        i_sample_stb = 1'b1;
        step();
        i_sample_stb = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_bclk"},  o_bclk,       1'b0);
        check1({tag, "_lrclk"}, o_lrclk,      1'b0);
        check1({tag, "_sdata"}, o_sdata,      1'b0);
        check1({tag, "_req"},   o_sample_req, 1'b0);
        check1({tag, "_urun"},  o_underrun,   1'b0);
        check1({tag, "_orun"},  o_overrun,    1'b0);
    endtask

    task automatic release_and_check(input string tag);
        i_rst_n = 1'b1;
        step();
        check1({tag, "_bclk_c1"}, o_bclk, 1'b0);
        step();
        check1({tag, "_bclk_c2"}, o_bclk, 1'b1);
        check1({tag, "_req_c2"},  o_sample_req, 1'b0);
        step();
        check1({tag, "_bclk_c3"}, o_bclk, 1'b1);
        step();
        check1({tag, "_bclk_c4"}, o_bclk, 1'b0);
        check1({tag, "_req_c4"},  o_sample_req, 1'b1);
        check1({tag, "_urun_c4"}, o_underrun, 1'b1);
        check1({tag, "_lr_c4"},   o_lrclk, 1'b0);
        step();
        check1({tag, "_req_c5"},  o_sample_req, 1'b0);
        check1({tag, "_urun_c5"}, o_underrun, 1'b0);
        collect_frame(frame_data, frame_lr);
        check32({tag, "_data"}, frame_data, 32'h0000_0000);
        check32({tag, "_lr"},   frame_lr,   c_LR_PATTERN);
    endtask

    task automatic frame_with_sample(input string tag, input logic [7:0] s, input logic [15:0] slot);
        strobe(s);
        check1({tag, "_orun_stb"}, o_overrun, 1'b0);
        wait_fall();
        check1({tag, "_req"},  o_sample_req, 1'b1);
        check1({tag, "_urun"}, o_underrun,   1'b0);
        step();
        collect_frame(frame_data, frame_lr);
        check32({tag, "_data"}, frame_data, {slot, slot});
        check32({tag, "_lr"},   frame_lr,   c_LR_PATTERN);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n      = 1'b0;
        i_sample     = 8'h00;
        i_sample_stb = 1'b0;
        repeat (3) step();
        check_reset_outputs("rst");

        release_and_check("boot");

        frame_with_sample("s_ff", 8'hFF, 16'h7F00);
        frame_with_sample("s_00", 8'h00, 16'h8000);
        frame_with_sample("s_80", 8'h80, 16'h0000);

        // Two strobes in one frame: second overwrites the first.
        strobe(8'h10);
        check1("ovr_first", o_overrun, 1'b0);
        strobe(8'hF0);
        check1("ovr_second", o_overrun, 1'b1);
        wait_fall();
        check1("ovr_req",  o_sample_req, 1'b1);
        check1("ovr_urun", o_underrun,   1'b0);
        check1("ovr_clr",  o_overrun,    1'b0);
        step();
        collect_frame(frame_data, frame_lr);
        check32("ovr_data", frame_data, 32'h7000_7000);

        // Strobe on the load edge itself (3 clocks after the k=31 fall).
        repeat (3) step();
        check1("coin_pre_bclk", o_bclk, 1'b1);
        i_sample     = 8'hC0;
        i_sample_stb = 1'b1;
        step();
        i_sample_stb = 1'b0;
        check1("coin_req",  o_sample_req, 1'b1);
        check1("coin_urun", o_underrun,   1'b0);
        check1("coin_orun", o_overrun,    1'b0);
        step();
        check1("coin_orun2", o_overrun, 1'b0);
        collect_frame(frame_data, frame_lr);
        check32("coin_data", frame_data, 32'h4000_4000);
        wait_fall();
        check1("coin_next_urun", o_underrun, 1'b1);
        step();
        collect_frame(frame_data, frame_lr);
        check32("coin_repeat_data", frame_data, 32'h4000_4000);

        // Reset in the middle of the right slot of a 0x7F00 frame.
        strobe(8'hFF);
        wait_fall();
        check1("mid_req", o_sample_req, 1'b1);
        repeat (20) wait_fall();
        step();
        step();
        check1("mid_bclk", o_bclk, 1'b1);
        check1("mid_lr",   o_lrclk, 1'b1);
        check1("mid_sd",   o_sdata, 1'b1);
        i_rst_n = 1'b0;
        step();
        check_reset_outputs("mid_rst");
        step();
        check_reset_outputs("mid_rst2");
        release_and_check("restart");

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
        check32("ucnt_one", {24'h0, o_underrun_count}, 32'h0000_0001);
        for (int f = 0; f < 300; f++) begin
            repeat (32) wait_fall();
        end
        check32("ucnt_sat", {24'h0, o_underrun_count}, 32'h0000_00FF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_audio_i2s_tx
`default_nettype wire
